// File: rtl/btn_cmd_ctrl_pkg.sv
// Shared encodings for the button command block: FSM states and count direction.
// The helper below defines which states allow the mode toggle.
package btn_cmd_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   localparam logic MODE_UP   = 1'b0;
   localparam logic MODE_DOWN = 1'b1;

   // Mode may only be flipped while the counter is not running.
   function automatic logic mode_toggle_allowed(input state_t st);
      return (st == ST_STOP) || (st == ST_CLEAR);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-FF synchronizer, tick-sampled shift-register debouncer,
// and a registered one-clock pulse on each accepted press (0->1 of the level).
module btn_debounce #(
   parameter int unsigned DB_DEPTH = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic btn,
   output logic press
);

   logic [1:0]          sync_q;
   logic [DB_DEPTH-1:0] shreg;
   logic                level_q;
   logic                level_prev;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q     <= '0;
         shreg      <= '0;
         level_q    <= 1'b0;
         level_prev <= 1'b0;
         press      <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn};
         if (tick)
            shreg <= {shreg[DB_DEPTH-2:0], sync_q[1]};
         // Level only moves on a unanimous window; mixed windows hold it.
         if (&shreg)
            level_q <= 1'b1;
         else if (~|shreg)
            level_q <= 1'b0;
         level_prev <= level_q;
         press      <= level_q & ~level_prev;
      end
   end

endmodule

// File: rtl/btn_cmd_ctrl.sv
// Button command block: shared sample tick, three debouncers and the
// STOP/RUN/CLEAR FSM producing run enable, clear pulse and count direction.
module btn_cmd_ctrl
   import btn_cmd_ctrl_pkg::*;
#(
   parameter int unsigned F_CLK    = 100_000_000,
   parameter int unsigned F_SAMPLE = 1_000,
   parameter int unsigned DB_DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_run_stop,
   input  logic       btn_clear,
   input  logic       btn_mode,
   output logic       o_run,
   output logic       o_clear,
   output logic       o_mode,
   output logic [1:0] o_state
);

   localparam int unsigned DIV = F_CLK / F_SAMPLE;
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] TERM = CW'(DIV - 1);

   logic [CW-1:0] tick_cnt;
   logic          tick;
   logic          rs_press;
   logic          clr_press;
   logic          mode_press;
   state_t        state;
   logic          mode_q;

   assign tick = (tick_cnt == TERM);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         tick_cnt <= '0;
      else if (tick)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + 1'b1;
   end

   btn_debounce #(.DB_DEPTH(DB_DEPTH)) u_db_run_stop (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .btn   (btn_run_stop),
      .press (rs_press)
   );

   btn_debounce #(.DB_DEPTH(DB_DEPTH)) u_db_clear (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .btn   (btn_clear),
      .press (clr_press)
   );

   btn_debounce #(.DB_DEPTH(DB_DEPTH)) u_db_mode (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .btn   (btn_mode),
      .press (mode_press)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ST_STOP;
         mode_q <= MODE_UP;
      end else begin
         case (state)
            ST_STOP: begin
               if (clr_press)
                  state <= ST_CLEAR;
               else if (rs_press)
                  state <= ST_RUN;
            end
            ST_RUN: begin
               if (rs_press)
                  state <= ST_STOP;
            end
            ST_CLEAR: state <= ST_STOP;
            default:  state <= ST_STOP;
         endcase
         if (mode_press && mode_toggle_allowed(state))
            mode_q <= ~mode_q;
      end
   end

   assign o_run   = (state == ST_RUN);
   assign o_clear = (state == ST_CLEAR);
   assign o_mode  = mode_q;
   assign o_state = state;

endmodule

// File: tb/tb_btn_cmd_ctrl.sv
// Bench for btn_cmd_ctrl: directed scenarios plus random button activity,
// every cycle compared against a sample-window reference model.
module tb_btn_cmd_ctrl;

   localparam int DIV = 10;
   localparam int DB  = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_run_stop = 1'b0;
   logic       btn_clear = 1'b0;
   logic       btn_mode = 1'b0;
   logic       o_run, o_clear, o_mode;
   logic [1:0] o_state;

   int n_checks = 0;
   int n_fail   = 0;

   btn_cmd_ctrl #(.F_CLK(1000), .F_SAMPLE(100), .DB_DEPTH(DB)) dut (
      .clk          (clk),
      .reset        (reset),
      .btn_run_stop (btn_run_stop),
      .btn_clear    (btn_clear),
      .btn_mode     (btn_mode),
      .o_run        (o_run),
      .o_clear      (o_clear),
      .o_mode       (o_mode),
      .o_state      (o_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: button index 0 = run_stop, 1 = clear, 2 = mode.
   int cyc;
   int d0[3], d1[3];
   int win[3][DB];
   int lvl[3], prv[3], prs[3];
   int mst, mmode;

   initial begin
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            cyc = 0; mst = 0; mmode = 0;
            for (int b = 0; b < 3; b++) begin
               d0[b] = 0; d1[b] = 0; lvl[b] = 0; prv[b] = 0; prs[b] = 0;
               for (int k = 0; k < DB; k++) win[b][k] = 0;
            end
         end else begin
            int  raw[3];
            int  ones, s1, nl;
            bit  tk;
            raw[0] = int'(btn_run_stop); raw[1] = int'(btn_clear); raw[2] = int'(btn_mode);
            tk = ((cyc % DIV) == DIV - 1);
            cyc++;
            if (prs[2] != 0 && mst != 1) mmode = 1 - mmode;
            case (mst)
               0: if (prs[1] != 0) mst = 2; else if (prs[0] != 0) mst = 1;
               1: if (prs[0] != 0) mst = 0;
               default: mst = 0;
            endcase
            for (int b = 0; b < 3; b++) begin
               s1 = d1[b]; d1[b] = d0[b]; d0[b] = raw[b];
               ones = 0;
               for (int k = 0; k < DB; k++) ones += win[b][k];
               nl = (ones == DB) ? 1 : (ones == 0) ? 0 : lvl[b];
               if (tk) begin
                  for (int k = 0; k < DB - 1; k++) win[b][k] = win[b][k+1];
                  win[b][DB-1] = s1;
               end
               prs[b] = (lvl[b] == 1 && prv[b] == 0) ? 1 : 0;
               prv[b] = lvl[b];
               lvl[b] = nl;
            end
         end
      end
   end

   // Per-cycle comparison and clear-pulse width monitor.
   bit chk_on = 1'b0;
   int clr_len = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (chk_on) begin
            if (reset) begin
               check("run",   o_run,   (mst == 1) ? 1 : 0);
               check("clear", o_clear, (mst == 2) ? 1 : 0);
               check("mode",  o_mode,  mmode);
               check("state", o_state, mst);
            end else begin
               check("rst_out", {o_run, o_clear, o_mode, o_state}, 0);
            end
            if (o_clear === 1'b1)
               clr_len++;
            else if (clr_len > 0) begin
               check("clear_width", clr_len, 1);
               clr_len = 0;
            end
         end
      end
   end

   task automatic drive(input bit rs, input bit clr, input bit md, input int n);
      @(negedge clk);
      btn_run_stop = rs; btn_clear = clr; btn_mode = md;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic press_run_wait();
      int lat;
      lat = 0;
      @(negedge clk);
      btn_run_stop = 1'b1;
      while (o_run !== 1'b1 && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      check("run_latency_ok", (lat <= 54) ? 1 : 0, 1);
      repeat (100 - lat) @(negedge clk);
      btn_run_stop = 1'b0;
      repeat (60) @(negedge clk);
   endtask

   initial begin
      #200_000_0;
      $display("FAIL watchdog timeout");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1);
   end

   initial begin
      chk_on = 1'b1;
      // 1: reset held with buttons toggling
      repeat (30) begin
         @(negedge clk);
         btn_run_stop = 1'($urandom); btn_clear = 1'($urandom); btn_mode = 1'($urandom);
      end
      drive(0, 0, 0, 1);
      reset = 1'b1;
      repeat (80) @(negedge clk);
      check("idle_state", o_state, 0);

      // 2: run/stop toggling
      press_run_wait();
      check("run_held", o_run, 1);
      press_run_wait();
      check("run_off", o_run, 0);
      check("stop_state", o_state, 0);

      // 3: short pulse and chatter on clear
      drive(0, 1, 0, 15);
      drive(0, 0, 0, 60);
      for (int i = 0; i < 20; i++) drive(0, (i % 2) == 0, 0, 3);
      drive(0, 0, 0, 80);
      check("chatter_state", o_state, 0);

      // 4: clear in STOP, then clear while RUN
      drive(0, 1, 0, 100);
      drive(0, 0, 0, 60);
      press_run_wait();
      drive(0, 1, 0, 100);
      drive(0, 0, 0, 60);
      check("clear_in_run", o_state, 1);

      // 5: mode ignored in RUN, toggles in STOP
      drive(0, 0, 1, 100);
      drive(0, 0, 0, 60);
      check("mode_in_run", o_mode, 0);
      press_run_wait();
      drive(0, 0, 1, 100);
      drive(0, 0, 0, 60);
      check("mode_toggle1", o_mode, 1);
      drive(0, 0, 1, 100);
      drive(0, 0, 0, 60);
      check("mode_toggle2", o_mode, 0);

      // mode held through reset release yields exactly one press
      @(negedge clk); reset = 1'b0; btn_mode = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (80) @(negedge clk);
      btn_mode = 1'b0;
      repeat (60) @(negedge clk);
      check("mode_thru_reset", o_mode, 1);

      // 6: simultaneous run_stop and clear in STOP
      drive(1, 1, 0, 100);
      drive(0, 0, 0, 60);
      check("simul_state", o_state, 0);

      // async reset mid-RUN
      press_run_wait();
      @(posedge clk);
      #2 reset = 1'b0;
      #1 check("async_rst_run", o_run, 0);
      check("async_rst_state", o_state, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // random activity
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 9) < 2) begin
            int bsel;
            bsel = $urandom_range(0, 2);
            for (int j = 0; j < 10; j++)
               drive(bsel == 0 && j % 2 == 0, bsel == 1 && j % 2 == 0, bsel == 2 && j % 2 == 0,
                     $urandom_range(1, 6));
         end else begin
            logic [2:0] m;
            m = 3'($urandom_range(0, 7));
            drive(m[0], m[1], m[2], $urandom_range(5, 110));
         end
         drive(0, 0, 0, $urandom_range(5, 110));
      end
      drive(0, 0, 0, 60);

      chk_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/btn_cmd_ctrl.md
Name: btn_cmd_ctrl

Overview:
Input-side command block for the counter/FND path. It debounces three raw push-buttons (run/stop, clear, mode) and detects their presses. A small FSM turns the presses into counter-control outputs: run enable, one-cycle clear pulse and up/down mode. It sits between board buttons and the counter, the opposite end of the display path.

Parameters:
F_CLK, 100_000_000, system clock frequency in Hz
F_SAMPLE, 1_000, debounce sample-tick rate in Hz
DB_DEPTH, 8, consecutive equal samples needed to accept a level change

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
btn_run_stop  input  1  raw button, async to clk, 1 = pressed
btn_clear  input  1  raw button, async to clk, 1 = pressed
btn_mode  input  1  raw button, async to clk, 1 = pressed
o_run  output  1  1 while counter must count
o_clear  output  1  one-clk pulse: counter must clear
o_mode  output  1  0 = count up, 1 = count down
o_state  output  2  FSM state: 0 STOP, 1 RUN, 2 CLEAR

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM=STOP. Tick counter, synchronizers, shift registers, debounced levels and edge registers all go to 0. Effect is immediate and holds mid-operation.
- Sample tick: counter of width $clog2(F_CLK/F_SAMPLE) runs 0..F_CLK/F_SAMPLE-1 and wraps. The tick is high for exactly one clk on the terminal count. It is shared by all three buttons.
- Per button: 2-FF synchronizer on clk. A DB_DEPTH-bit shift register shifts the synced bit in on each tick.
- Debounced level goes to 1 when the register is all ones and to 0 when it is all zeros; otherwise it holds.
- Press event is a one-clk pulse on the 0->1 edge of the debounced level, from a registered compare. Release generates nothing.
- Glitches shorter than DB_DEPTH ticks never change the debounced level.
- Button held through reset release: it debounces to 1 after DB_DEPTH ticks and generates exactly one press event.
- FSM transitions, evaluated on the press pulses:
  - STOP: clear press -> CLEAR; else run_stop press -> RUN; else stay. Simultaneous clear and run_stop -> CLEAR (clear has priority).
  - RUN: run_stop press -> STOP. Clear and mode presses are ignored.
  - CLEAR: always -> STOP after one cycle. Presses arriving in this cycle are dropped.
- Outputs decode from the state register (no extra latency): o_run=(state==RUN), o_clear=(state==CLEAR), o_state=state.
- o_mode is a register that toggles on a mode press only in STOP or CLEAR; it is unaffected by FSM transitions.
- Latency from a stable raw press to o_run/o_clear change: 2 clk sync + DB_DEPTH ticks (±1 tick phase) + 1 clk edge + 1 clk FSM.
- Encoding value 3 is illegal and must recover to STOP on the next clk.

Decomposition:
- Shared package: state encodings (ST_STOP=2'd0, ST_RUN=2'd1, ST_CLEAR=2'd2) and the mode encodings (MODE_UP=0, MODE_DOWN=1).
- Sub-module btn_debounce holds the synchronizer, shift register, debounced level and press pulse, with sample tick as input. It is instantiated 3x.
- Tick generator and FSM stay in the top.

Test Plan:
Sim parameters for all scenarios: F_CLK=1000, F_SAMPLE=100 (tick every 10 clk), DB_DEPTH=4.
1. reset=0 at t0, buttons toggling -> o_run=0, o_clear=0, o_mode=0, o_state=0 throughout reset. After release, state stays 0 with no presses.
2. btn_run_stop high 100 clk -> o_run rises within 54 clk of press and stays 1 after release. A second 100-clk press -> o_run returns to 0, o_state=0.
3. btn_clear 15-clk pulse and a chatter burst (1/0 every 3 clk for 60 clk, then low) -> no press event; all outputs unchanged.
4. In STOP, btn_clear high 100 clk -> o_clear=1 for exactly one clk, o_state 0->2->0, o_run stays 0. The same press while in RUN -> no o_clear.
5. btn_mode press in STOP -> o_mode 0->1; second press -> 1->0. Press while RUN -> o_mode unchanged.
6. btn_run_stop and btn_clear pressed on the same clk in STOP -> CLEAR then STOP, o_run never 1. Separately, reset=0 mid-RUN -> o_run=0 before the next clk edge.
